register_file_banked: RTL
=========================

Name: register_file_banked

Overview:
- Parametrised next-generation CPU register file: NUM_REGS x DATA_W registers, one of them the program counter.
- Provides three combinational read ports (Rn, Rm, Rs) and one synchronous write port.
- The write address is selected from the instruction register or the control unit.
- Adds features the previous generation lacks: a dedicated PC load path, PC auto-increment, mode-banked registers and optional write-to-read forwarding.
- Sits between the instruction register / control unit and the ALU operand buses.

Parameters:
- DATA_W, 32, register and bus width.
- NUM_REGS, 16, register count; power of two, >= 4.
- ADDR_W, log2(NUM_REGS), register index width (derived).
- PC_INDEX, NUM_REGS-1, index of the PC register.
- PC_INC, 4, PC increment step.
- RESET_PC, 0, PC value after reset.
- BANK_BASE, NUM_REGS-3, first banked index; indices BANK_BASE..PC_INDEX-1 are banked.
- BYPASS, 1, 1 = forward the write data to reads of the same index in the same cycle.

Ports:
- Clk  input  1  clock, rising edge active.
- RESET  input  1  synchronous reset, active-low; sampled on rising Clk.
- in  input  DATA_W  write data.
- Pcin  input  DATA_W  PC load value.
- RSLCT  input  4*ADDR_W  field select: [4A-1:3A] Rn, [3A-1:2A] Rm, [2A-1:A] Rs, [A-1:0] Rd (A = ADDR_W).
- CU_RD  input  ADDR_W  control-unit write index.
- IR_CU  input  1  1 = write index from RSLCT Rd field; 0 = CU_RD.
- MODE  input  1  bank select: 0 = bank 0, 1 = bank 1.
- LOAD  input  1  write enable for the general write port.
- LOADPC  input  1  PC load from Pcin.
- INC_PC  input  1  PC += PC_INC.
- Rn, Rm, Rs  output  DATA_W  read data for the RSLCT fields.
- PCout  output  DATA_W  current PC.

Behaviour:
- **Reset:** RESET==0 at a rising Clk clears all general registers in both banks to 0 and sets PC = RESET_PC.
  - Reset overrides LOAD, LOADPC and INC_PC in that cycle.
  - Outputs reflect the reset state combinationally after that edge.
  - Reset asserted mid-sequence discards any same-cycle write.
- **Write index:** wa = IR_CU ? RSLCT[A-1:0] : CU_RD.
- **Write port:** LOAD==1 at a rising edge writes `in` into reg[wa].
  - If wa is in the banked range, only the copy selected by MODE is written.
  - If wa == PC_INDEX, the write targets PC, subject to the PC priority rule.
- **PC update, one per edge, priority high to low:**
  1. LOADPC: PC <= Pcin.
  2. LOAD with wa == PC_INDEX: PC <= in.
  3. INC_PC: PC <= PC + PC_INC, modulo 2^DATA_W (wraps; no flag).
  4. Otherwise PC holds.
- **PC isolation:** a LOAD to a non-PC index concurrent with LOADPC or INC_PC performs both updates independently.
- **Reads:**
  - Rn/Rm/Rs are combinational from their RSLCT fields; there are no read enables.
  - Banked indices return the MODE-selected copy; MODE switches take effect immediately.
  - Reading PC_INDEX returns the registered PC.
- **Forwarding (BYPASS=1):**
  - When LOAD==1 and RESET==1, a read whose index equals wa, for a non-PC index in the same bank, returns `in` in the same cycle.
  - PC reads are never forwarded.
  - With BYPASS=0, reads return the stored value until after the edge.
- **PCout:** always equals the registered PC; it never forwards Pcin.
- **Concurrency:** identical indices on multiple read fields are legal, and all such ports return the same value.
- **Latency:** writes are visible one edge later (zero with BYPASS on a matching read); reads have zero cycles of latency.

Test Plan:
1. **Reset:** hold RESET=0 for 2 edges with LOAD=1, in=5 -> all Rn/Rm/Rs=0, PCout=RESET_PC=0; release RESET -> values unchanged until a write occurs.
2. **Write/read via IR and CU:**
   - IR_CU=1, Rd=3, in=0xA5, LOAD=1; then RSLCT Rn=3 -> Rn=0xA5.
   - IR_CU=0, CU_RD=7, in=0x11 -> Rm(7)=0x11; reg 3 unchanged.
3. **PC priority:**
   - INC_PC x3 from 0 -> PCout=12.
   - LOADPC=1, Pcin=0x100 with LOAD=1, wa=15, in=0x200, INC_PC=1 -> PCout=0x100.
   - Next edge: LOAD only to wa=15, in=0x200 -> 0x200.
   - PC=0xFFFFFFFC plus INC_PC -> 0.
4. **Banking:**
   - MODE=0, write reg13=0x13; MODE=1, write reg13=0x99.
   - Read 13 with MODE=0 -> 0x13; MODE=1 -> 0x99; reg12 shows one value in both modes.
5. **Forwarding:**
   - BYPASS=1: LOAD=1, wa=4, in=0x77, Rs=4 -> Rs=0x77 before the edge.
   - BYPASS=0 instance: old value before the edge, 0x77 after.
   - wa=15 -> Rn(15) still shows the old PC before the edge.
6. **Reset mid-operation:** set reg2=9, PC=0x40; assert RESET=0 with LOAD=1 to reg2, INC_PC=1 -> reg2=0, PCout=0.

Source files
------------

// File: rtl/register_file_banked.sv
// ---------------------------------------------------------------------------
// register_file_banked
//
// CPU register file: NUM_REGS x DATA_W registers, the top index being the
// program counter. Indices BANK_BASE..PC_INDEX-1 exist twice (bank 0 and
// bank 1, selected by MODE); all lower indices are shared by both banks.
//
// Ports
//   Clk     in   rising-edge clock
//   RESET   in   synchronous reset, active low
//   in      in   general write data
//   Pcin    in   PC load value
//   RSLCT   in   {Rn, Rm, Rs, Rd} register index fields
//   CU_RD   in   control-unit write index
//   IR_CU   in   1: write index from RSLCT Rd field, 0: from CU_RD
//   MODE    in   bank select for banked indices (reads and writes)
//   LOAD    in   general write enable
//   LOADPC  in   load PC from Pcin
//   INC_PC  in   PC += PC_INC
//   Rn/Rm/Rs out combinational read data for the RSLCT fields
//   PCout   out  registered PC
// ---------------------------------------------------------------------------
module register_file_banked #(
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 16,
  parameter int                ADDR_W    = $clog2(NUM_REGS),
  parameter int                PC_INDEX  = NUM_REGS - 1,
  parameter int                PC_INC    = 4,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter int                BANK_BASE = NUM_REGS - 3,
  parameter int                BYPASS    = 1
) (
  input  logic                Clk,
  input  logic                RESET,
  input  logic [DATA_W-1:0]   in,
  input  logic [DATA_W-1:0]   Pcin,
  input  logic [4*ADDR_W-1:0] RSLCT,
  input  logic [ADDR_W-1:0]   CU_RD,
  input  logic                IR_CU,
  input  logic                MODE,
  input  logic                LOAD,
  input  logic                LOADPC,
  input  logic                INC_PC,
  output logic [DATA_W-1:0]   Rn,
  output logic [DATA_W-1:0]   Rm,
  output logic [DATA_W-1:0]   Rs,
  output logic [DATA_W-1:0]   PCout
);

  localparam int                NUM_BANKED = PC_INDEX - BANK_BASE;
  localparam logic [ADDR_W-1:0] PC_ADDR    = ADDR_W'(PC_INDEX);
  localparam logic [DATA_W-1:0] PC_STEP    = DATA_W'(PC_INC);

  // gpr holds every non-PC index; for banked indices it is the bank-0 copy.
  // bnk holds the bank-1 copies of the banked indices only.
  logic [DATA_W-1:0] gpr [PC_INDEX];
  logic [DATA_W-1:0] bnk [NUM_BANKED];
  logic [DATA_W-1:0] pc;

  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] rn_idx;
  logic [ADDR_W-1:0] rm_idx;
  logic [ADDR_W-1:0] rs_idx;
  logic              wr_pc;

  assign rn_idx = RSLCT[4*ADDR_W-1:3*ADDR_W];
  assign rm_idx = RSLCT[3*ADDR_W-1:2*ADDR_W];
  assign rs_idx = RSLCT[2*ADDR_W-1:ADDR_W];
  assign wa     = IR_CU ? RSLCT[ADDR_W-1:0] : CU_RD;
  assign wr_pc  = LOAD && (wa == PC_ADDR);

  // -------------------------------------------------------------------------
  // Register storage and PC update
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!RESET) begin
      for (int i = 0; i < PC_INDEX; i++) begin
        gpr[i] <= '0;
      end
      for (int j = 0; j < NUM_BANKED; j++) begin
        bnk[j] <= '0;
      end
      pc <= RESET_PC;
    end else begin
      // Bank-0 / shared copies: a banked index is only written here in MODE 0.
      for (int i = 0; i < PC_INDEX; i++) begin
        if (LOAD && (wa == ADDR_W'(i)) && !(MODE && (i >= BANK_BASE))) begin
          gpr[i] <= in;
        end
      end
      for (int j = 0; j < NUM_BANKED; j++) begin
        if (LOAD && MODE && (wa == ADDR_W'(BANK_BASE + j))) begin
          bnk[j] <= in;
        end
      end

      // PC: explicit load beats a general write to PC, which beats increment.
      if (LOADPC) begin
        pc <= Pcin;
      end else if (wr_pc) begin
        pc <= in;
      end else if (INC_PC) begin
        pc <= pc + PC_STEP;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] stored_value(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    if (idx == PC_ADDR) begin
      v = pc;
    end else begin
      for (int i = 0; i < PC_INDEX; i++) begin
        if (idx == ADDR_W'(i)) begin
          v = gpr[i];
        end
      end
      for (int j = 0; j < NUM_BANKED; j++) begin
        if (MODE && (idx == ADDR_W'(BANK_BASE + j))) begin
          v = bnk[j];
        end
      end
    end
    return v;
  endfunction

  // Reads and the pending write share MODE, so an index match is always a
  // same-bank match. PC reads always show the registered PC.
  function automatic logic fwd_hit(input logic [ADDR_W-1:0] idx);
    return (BYPASS != 0) && LOAD && RESET && (idx == wa) && (idx != PC_ADDR);
  endfunction

  always_comb begin
    Rn = stored_value(rn_idx);
    if (fwd_hit(rn_idx)) begin
      Rn = in;
    end
  end

  always_comb begin
    Rm = stored_value(rm_idx);
    if (fwd_hit(rm_idx)) begin
      Rm = in;
    end
  end

  always_comb begin
    Rs = stored_value(rs_idx);
    if (fwd_hit(rs_idx)) begin
      Rs = in;
    end
  end

  assign PCout = pc;

endmodule
